// File: rtl/s2_seq_pkg.sv
// Shared constants and FSM state type for the stage-2 convolution sequencer.
package s2_seq_pkg;

  localparam int N_FILT       = 4;
  localparam int OUT_DIM      = 6;
  localparam int POS_PER_FILT = OUT_DIM * OUT_DIM;
  localparam int DIR_W        = (N_FILT > 1) ? $clog2(N_FILT) : 1;
  localparam int POS_W        = $clog2(POS_PER_FILT);
  localparam int RC_W         = $clog2(OUT_DIM);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } seq_state_e;

endpackage

// File: rtl/s2_conv_sequencer_if.sv
// Handshake/index bundle between the layer controller, the stage-2 sequencer
// and the datapath. The perf counter signals exist only when S2_SEQ_PERF_EN
// is defined.
interface s2_conv_sequencer_if;
  import s2_seq_pkg::*;

  logic             start;
  logic             abort;
  logic             stall;
  logic [DIR_W-1:0] proc_dir;
  logic [POS_W-1:0] proc_counter;
  logic [RC_W-1:0]  win_row;
  logic [RC_W-1:0]  win_col;
  logic             proc_valid;
  logic             wload_req;
  logic             busy;
  logic             done;
`ifdef S2_SEQ_PERF_EN
  logic [15:0]      run_cycles;
  logic [15:0]      stall_cycles;

  modport master (
    output start, abort, stall,
    input  proc_dir, proc_counter, win_row, win_col,
    input  proc_valid, wload_req, busy, done,
    input  run_cycles, stall_cycles
  );

  modport slave (
    input  start, abort, stall,
    output proc_dir, proc_counter, win_row, win_col,
    output proc_valid, wload_req, busy, done,
    output run_cycles, stall_cycles
  );
`else
  modport master (
    output start, abort, stall,
    input  proc_dir, proc_counter, win_row, win_col,
    input  proc_valid, wload_req, busy, done
  );

  modport slave (
    input  start, abort, stall,
    output proc_dir, proc_counter, win_row, win_col,
    output proc_valid, wload_req, busy, done
  );
`endif

endinterface

// File: rtl/s2_pos_counter.sv
// Row/column/linear position counter over the OUT_DIM x OUT_DIM output plane.
// Holds the next position to issue; wraps to 0 after the last position.
module s2_pos_counter
  import s2_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [RC_W-1:0]  row,
  output logic [RC_W-1:0]  col,
  output logic [POS_W-1:0] lin,
  output logic             last
);

  localparam logic [RC_W-1:0] MAX_RC = RC_W'(OUT_DIM - 1);

  assign last = (row == MAX_RC) && (col == MAX_RC);

  // Advance column-major-within-row; the three views stay in lockstep.
  always_ff @(posedge clk) begin
    if (reset || clr || (en && last)) begin
      row <= '0;
      col <= '0;
      lin <= '0;
    end else if (en) begin
      lin <= lin + POS_W'(1);
      if (col == MAX_RC) begin
        col <= '0;
        row <= row + RC_W'(1);
      end else begin
        col <= col + RC_W'(1);
      end
    end
  end

endmodule

// File: rtl/s2_conv_sequencer.sv
// Stage-2 convolution sequencer: steps every filter through every output
// position, with a weight-load gap before each filter, stall handling,
// a pipeline drain and a one-cycle done pulse. All outputs are registered.
// Optional S2_SEQ_PERF_EN adds saturating run/stall cycle counters.
module s2_conv_sequencer
  import s2_seq_pkg::*;
#(
  parameter int WEIGHT_LOAD_CYC = 2,
  parameter int PIPE_LAT        = 1
) (
  input logic                 clk,
  input logic                 reset,
  s2_conv_sequencer_if.slave  bus
);

  localparam logic [7:0]       LAST_LD  = 8'(WEIGHT_LOAD_CYC - 1);
  localparam logic [7:0]       LAST_DR  = (PIPE_LAT > 0) ? 8'(PIPE_LAT - 1) : 8'd0;
  localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(N_FILT - 1);

  seq_state_e       state;
  logic [7:0]       ld_cnt;
  logic [7:0]       dr_cnt;
  logic             last_issued;

  logic [DIR_W-1:0] proc_dir_q;
  logic [POS_W-1:0] proc_counter_q;
  logic [RC_W-1:0]  win_row_q;
  logic [RC_W-1:0]  win_col_q;
  logic             proc_valid_q;
  logic             wload_req_q;
  logic             busy_q;
  logic             done_q;

  logic             run_slot;
  logic             issue;
  logic             stall_hit;
  logic [RC_W-1:0]  pos_row;
  logic [RC_W-1:0]  pos_col;
  logic [POS_W-1:0] pos_lin;
  logic             pos_last;

  // An issue slot is any edge whose following cycle is a RUN cycle that may
  // carry a new position: leaving the final LOAD cycle, or staying in RUN
  // while the filter still has positions left.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    run_slot = 1'b0;
    if (!bus.abort) begin
      if (state == LOAD && ld_cnt == LAST_LD) run_slot = 1'b1;
      if (state == RUN && !last_issued)       run_slot = 1'b1;
    end
  end

  assign issue     = run_slot && !bus.stall;
  assign stall_hit = run_slot && bus.stall;

  s2_pos_counter u_pos (
    .clk   (clk),
    .reset (reset),
    .en    (issue),
    .clr   (state == IDLE),
    .row   (pos_row),
    .col   (pos_col),
    .lin   (pos_lin),
    .last  (pos_last)
  );

  // Main FSM with registered outputs; the issued position is latched into the
  // output indices so they hold through stalls and the drain.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ld_cnt         <= '0;
      dr_cnt         <= '0;
      last_issued    <= 1'b0;
      proc_dir_q     <= '0;
      proc_counter_q <= '0;
      win_row_q      <= '0;
      win_col_q      <= '0;
      proc_valid_q   <= 1'b0;
      wload_req_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else if (bus.abort && state != IDLE) begin
      state          <= IDLE;
      last_issued    <= 1'b0;
      proc_dir_q     <= '0;
      proc_counter_q <= '0;
      win_row_q      <= '0;
      win_col_q      <= '0;
      proc_valid_q   <= 1'b0;
      wload_req_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      proc_valid_q <= 1'b0;
      done_q       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state       <= LOAD;
            ld_cnt      <= '0;
            last_issued <= 1'b0;
            proc_dir_q  <= '0;
            wload_req_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_cnt == LAST_LD) begin
            state       <= RUN;
            wload_req_q <= 1'b0;
          end else begin
            ld_cnt <= ld_cnt + 8'd1;
          end
        end
        RUN: begin
          if (last_issued) begin
            last_issued <= 1'b0;
            if (proc_dir_q == LAST_DIR) begin
              if (PIPE_LAT == 0) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                state  <= DRAIN;
                dr_cnt <= '0;
              end
            end else begin
              state          <= LOAD;
              ld_cnt         <= '0;
              proc_dir_q     <= proc_dir_q + DIR_W'(1);
              proc_counter_q <= '0;
              win_row_q      <= '0;
              win_col_q      <= '0;
              wload_req_q    <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (dr_cnt == LAST_DR) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            dr_cnt <= dr_cnt + 8'd1;
          end
        end
        DONE: begin
          state          <= IDLE;
          proc_dir_q     <= '0;
          proc_counter_q <= '0;
          win_row_q      <= '0;
          win_col_q      <= '0;
          busy_q         <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (issue) begin
        proc_valid_q   <= 1'b1;
        proc_counter_q <= pos_lin;
        win_row_q      <= pos_row;
        win_col_q      <= pos_col;
        last_issued    <= pos_last;
      end
    end
  end

  assign bus.proc_dir     = proc_dir_q;
  assign bus.proc_counter = proc_counter_q;
  assign bus.win_row      = win_row_q;
  assign bus.win_col      = win_col_q;
  assign bus.proc_valid   = proc_valid_q;
  assign bus.wload_req    = wload_req_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

`ifdef S2_SEQ_PERF_EN
  logic [15:0] run_cycles_q;
  logic [15:0] stall_cycles_q;

  // Per-pass saturating counts of issued and stalled RUN slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cycles_q   <= '0;
      stall_cycles_q <= '0;
    end else if (state == IDLE && bus.start && !bus.abort) begin
      run_cycles_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (issue && run_cycles_q != 16'hFFFF)       run_cycles_q   <= run_cycles_q + 16'd1;
      if (stall_hit && stall_cycles_q != 16'hFFFF) stall_cycles_q <= stall_cycles_q + 16'd1;
    end
  end

  assign bus.run_cycles   = run_cycles_q;
  assign bus.stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_s2_conv_sequencer.sv
// Self-checking bench for s2_conv_sequencer: table of stall scenarios over full
// passes, plus hand-written reset, abort and start-while-busy sequences.
module tb_s2_conv_sequencer;
  import s2_seq_pkg::*;

  typedef struct {
    int stall_dir;
    int stall_pos;
    int stall_len;
    int exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[4];

  always #5 clk = ~clk;

  s2_conv_sequencer_if bus();

  s2_conv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_dir"},   32'(bus.proc_dir), 0);
    check({tag, "_cnt"},   32'(bus.proc_counter), 0);
    check({tag, "_row"},   32'(bus.win_row), 0);
    check({tag, "_col"},   32'(bus.win_col), 0);
    check({tag, "_valid"}, 32'(bus.proc_valid), 0);
    check({tag, "_wload"}, 32'(bus.wload_req), 0);
    check({tag, "_busy"},  32'(bus.busy), 0);
    check({tag, "_done"},  32'(bus.done), 0);
  endtask

  // One full pass from a start pulse; the stall record freezes issue for
  // stall_len slots right after the named position appears.
  task automatic run_pass(input vec_t v);
    int exp_dir = 0, exp_pos = 0, n_valid = 0, done_cyc = -1;
    int wl_cnt = 0, wl_bad = 0, order_bad = 0;
    int stall_left = 0, n_hold = 0, hold_bad = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (stall_left > 0) begin
        n_hold++;
        if (bus.proc_valid || 32'(bus.proc_dir) != v.stall_dir ||
            32'(bus.proc_counter) != v.stall_pos) hold_bad++;
        stall_left--;
        if (stall_left == 0) bus.stall = 1'b0;
      end
      if (bus.wload_req) begin
        wl_cnt++;
        if (bus.proc_valid) wl_bad++;
      end
      if (bus.proc_valid) begin
        if (exp_pos == 0) begin
          if (wl_cnt != 2) wl_bad++;
          wl_cnt = 0;
        end
        if (32'(bus.proc_dir) != exp_dir || 32'(bus.proc_counter) != exp_pos ||
            32'(bus.win_row) != exp_pos / OUT_DIM || 32'(bus.win_col) != exp_pos % OUT_DIM)
          order_bad++;
        n_valid++;
        if (v.stall_len > 0 && exp_dir == v.stall_dir && exp_pos == v.stall_pos) begin
          bus.stall  = 1'b1;
          stall_left = v.stall_len;
        end
        exp_pos++;
        if (exp_pos == POS_PER_FILT) begin
          exp_pos = 0;
          exp_dir++;
        end
      end
      if (bus.done) begin
        done_cyc = cyc;
        check("busy_at_done", 32'(bus.busy), 1);
      end
    end
    bus.stall = 1'b0;
    check("done_cycle", done_cyc, v.exp_done);
    check("valid_count", n_valid, 144);
    check("filters_done", exp_dir, N_FILT);
    check("order_errs", order_bad, 0);
    check("wload_errs", wl_bad, 0);
    check("stall_hold_cycles", n_hold, v.stall_len);
    check("stall_hold_errs", hold_bad, 0);
`ifdef S2_SEQ_PERF_EN
    check("run_cycles", 32'(bus.run_cycles), 144);
    check("stall_cycles", 32'(bus.stall_cycles), v.stall_len);
`endif
    @(negedge clk);
    check_idle_outputs("post_done");
`ifdef S2_SEQ_PERF_EN
    check("run_cycles_hold", 32'(bus.run_cycles), 144);
`endif
  endtask

  initial begin
    int found, n_done, n_busy, done_cyc;

    vecs[0] = '{stall_dir: 0, stall_pos: 0,  stall_len: 0, exp_done: 154};
    vecs[1] = '{stall_dir: 1, stall_pos: 17, stall_len: 5, exp_done: 159};
    vecs[2] = '{stall_dir: 2, stall_pos: 0,  stall_len: 3, exp_done: 157};
    vecs[3] = '{stall_dir: 3, stall_pos: 34, stall_len: 1, exp_done: 155};

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.stall = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
`ifdef S2_SEQ_PERF_EN
    check("reset_run_cycles", 32'(bus.run_cycles), 0);
    check("reset_stall_cycles", 32'(bus.stall_cycles), 0);
`endif
    reset = 1'b0;

    // Reset in the middle of a pass returns everything to zero.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (50) @(negedge clk);
    check("mid_busy", 32'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("mid_reset");

    for (int i = 0; i < 4; i++) run_pass(vecs[i]);

    // Abort at filter 2 position 10.
    found = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int cyc = 0; cyc < 300 && found == 0; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.proc_valid && bus.proc_dir == 2 && bus.proc_counter == 10) found = 1;
    end
    check("abort_reached", found, 1);
    bus.abort = 1'b1;
    bus.stall = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.stall = 1'b0;
    check_idle_outputs("abort");
    n_done = 0;
    n_busy = 0;
    repeat (20) begin
      @(negedge clk);
      n_done += int'(bus.done);
      n_busy += int'(bus.busy);
    end
    check("abort_no_done", n_done, 0);
    check("abort_stays_idle", n_busy, 0);
    run_pass(vecs[0]);

    // Start pulses while busy (LOAD, RUN, DONE) are ignored.
    n_done   = 0;
    done_cyc = -1;
    @(negedge clk);
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == 1 || cyc == 60) ? 1'b1 : 1'b0;
      if (bus.done) begin
        n_done++;
        done_cyc  = cyc;
        bus.start = 1'b1;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_start_done_cycle", done_cyc, 154);
    check("busy_start_after_done", 32'(bus.busy), 0);
    n_busy = 0;
    repeat (30) begin
      @(negedge clk);
      n_done += int'(bus.done);
      n_busy += int'(bus.busy);
    end
    check("one_done_per_start", n_done, 1);
    check("ignored_start_idle", n_busy, 0);

    // start and abort together in IDLE: abort wins.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_idle_outputs("start_abort");
    n_busy = 0;
    repeat (5) begin
      @(negedge clk);
      n_busy += int'(bus.busy);
    end
    check("start_abort_idle", n_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
